// File: rtl/wb_scheduler.sv
// Write-back scheduler: up to seven result sources share one register-bank write port.
// Define WB_RR_EN for round-robin arbitration; otherwise fixed priority, lowest index wins.
module wb_scheduler #(
  parameter int N_SRC = 7,
  parameter int REG_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SRC-1:0]       req,
  input  logic [N_SRC*REG_W-1:0] req_rd,
  output logic [N_SRC-1:0]       req_ready,
  input  logic                   stall,
  output logic [2:0]             wd_sel,
  output logic                   reg_write,
  output logic [REG_W-1:0]       write_reg,
  output logic [N_SRC-1:0]       wb_done,
  output logic                   busy
);

  logic [N_SRC-1:0] pending_q, pending_d;
  logic [REG_W-1:0] rd_q [N_SRC];
  logic [REG_W-1:0] rd_d [N_SRC];
  logic [2:0]       wd_sel_q, wd_sel_d;
  logic [REG_W-1:0] write_reg_q, write_reg_d;
  logic             reg_write_q, reg_write_d;
  logic [N_SRC-1:0] wb_done_q, wb_done_d;
  logic             grant;
  logic [2:0]       win;

  assign grant = !stall && (|pending_q);

`ifdef WB_RR_EN
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] idx;
  logic       found;

  // Search upward from the pointer, wrapping at N_SRC.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'(N_SRC)) idx = idx - 4'(N_SRC);
      if (!found && pending_q[idx[2:0]]) begin
        found = 1'b1;
        win   = idx[2:0];
      end
    end
    ptr_d = ptr_q;
    if (grant) ptr_d = (win == 3'(N_SRC - 1)) ? 3'd0 : win + 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending_q[i]) win = 3'(i);
    end
  end
`endif

  always_comb begin
    pending_d   = pending_q;
    wd_sel_d    = wd_sel_q;
    write_reg_d = write_reg_q;
    reg_write_d = 1'b0;
    wb_done_d   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      rd_d[i] = rd_q[i];
      if (req[i] && !pending_q[i]) begin
        pending_d[i] = 1'b1;
        rd_d[i]      = req_rd[REG_W*i +: REG_W];
      end
    end
    // The winner is already pending, so capture above never touches its slot.
    if (grant) begin
      pending_d[win] = 1'b0;
      wd_sel_d       = win;
      write_reg_d    = rd_q[win];
      wb_done_d[win] = 1'b1;
      reg_write_d    = |rd_q[win];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q   <= '0;
      wd_sel_q    <= '0;
      write_reg_q <= '0;
      reg_write_q <= 1'b0;
      wb_done_q   <= '0;
      for (int i = 0; i < N_SRC; i++) rd_q[i] <= '0;
    end else begin
      pending_q   <= pending_d;
      wd_sel_q    <= wd_sel_d;
      write_reg_q <= write_reg_d;
      reg_write_q <= reg_write_d;
      wb_done_q   <= wb_done_d;
      for (int i = 0; i < N_SRC; i++) rd_q[i] <= rd_d[i];
    end
  end

  assign req_ready = ~pending_q;
  assign busy      = |pending_q;
  assign wd_sel    = wd_sel_q;
  assign write_reg = write_reg_q;
  assign reg_write = reg_write_q;
  assign wb_done   = wb_done_q;

endmodule

// File: tb/tb_wb_scheduler.sv
// Bench for wb_scheduler: expected grants are queued as stimulus is driven and
// popped by a monitor whenever a done pulse appears.
module tb_wb_scheduler;

  localparam int N_SRC = 7;
  localparam int REG_W = 5;
  localparam int W     = 3 + REG_W + 1;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_SRC-1:0]       req;
  logic [N_SRC*REG_W-1:0] req_rd;
  logic [N_SRC-1:0]       req_ready;
  logic                   stall;
  logic [2:0]             wd_sel;
  logic                   reg_write;
  logic [REG_W-1:0]       write_reg;
  logic [N_SRC-1:0]       wb_done;
  logic                   busy;

  int tests_run = 0;
  int fails     = 0;
  logic [W-1:0] exp_q[$];

  wb_scheduler #(.N_SRC(N_SRC), .REG_W(REG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_rd    (req_rd),
    .req_ready (req_ready),
    .stall     (stall),
    .wd_sel    (wd_sel),
    .reg_write (reg_write),
    .write_reg (write_reg),
    .wb_done   (wb_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int src, input logic [REG_W-1:0] rd);
    req[src]                = 1'b1;
    req_rd[REG_W*src +: REG_W] = rd;
  endtask

  task automatic expect_grant(input int src, input logic [REG_W-1:0] rd);
    exp_q.push_back({3'(src), rd, (rd != '0)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: every grant must match the head of the expected queue.
  always @(posedge clk) begin
    logic [W-1:0]     e;
    logic [N_SRC-1:0] d;
    #1;
    if (!reset) begin
      if (wb_done != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(wb_done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          d = '0;
          d[e[W-1 -: 3]] = 1'b1;
          check("grant_sel",  32'(wd_sel),    32'(e[W-1 -: 3]));
          check("grant_rd",   32'(write_reg), 32'(e[REG_W:1]));
          check("grant_we",   32'(reg_write), 32'(e[0]));
          check("grant_done", 32'(wb_done),   32'(d));
        end
      end else begin
        check("idle_we", 32'(reg_write), 32'd0);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    req    = '0;
    req_rd = '0;
    stall  = 1'b0;
    idle(2);
    check("rst_ready", 32'(req_ready), 32'h7f);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_sel",   32'(wd_sel),    32'd0);
    check("rst_wreg",  32'(write_reg), 32'd0);
    check("rst_we",    32'(reg_write), 32'd0);
    check("rst_done",  32'(wb_done),   32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(1);

    // Single request, source 3, rd 9: latency and req_ready timing.
    @(negedge clk);
    post(3, 5'd9);
    expect_grant(3, 5'd9);
    tick();
    check("t1_ready_k", 32'(req_ready[3]), 32'd0);
    check("t1_busy_k",  32'(busy),         32'd1);
    @(negedge clk);
    req = '0;
    tick();
    check("t1_done_k1",  32'(wb_done),      32'h08);
    check("t1_we_k1",    32'(reg_write),    32'd1);
    check("t1_ready_k1", 32'(req_ready[3]), 32'd1);
    tick();
    check("t1_done_k2", 32'(wb_done), 32'd0);
    idle(2);

    // Lone grant of source 2 (sets round-robin pointer to 3).
    @(negedge clk);
    post(2, 5'd7);
    expect_grant(2, 5'd7);
    @(negedge clk);
    req = '0;
    idle(3);

    // Simultaneous requests 0, 2, 5.
    @(negedge clk);
    post(0, 5'd1);
    post(2, 5'd2);
    post(5, 5'd3);
`ifdef WB_RR_EN
    expect_grant(5, 5'd3);
    expect_grant(0, 5'd1);
    expect_grant(2, 5'd2);
`else
    expect_grant(0, 5'd1);
    expect_grant(2, 5'd2);
    expect_grant(5, 5'd3);
`endif
    @(negedge clk);
    req = '0;
    idle(5);

    // Write to $zero: done pulses, write enable stays low.
    @(negedge clk);
    post(1, 5'd0);
    expect_grant(1, 5'd0);
    @(negedge clk);
    req = '0;
    idle(3);

    // Stall holds source 4 for three cycles.
    @(negedge clk);
    stall = 1'b1;
    post(4, 5'd17);
    expect_grant(4, 5'd17);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_we",   32'(reg_write), 32'd0);
      check("stall_busy", 32'(busy),      32'd1);
      check("stall_sel",  32'(wd_sel),    32'd1);
      @(negedge clk);
      req = '0;
    end
    stall = 1'b0;
    tick();
    check("stall_grant", 32'(wb_done), 32'h10);
    idle(3);

    // Request while pending: second request from source 6 is ignored.
    @(negedge clk);
    stall = 1'b1;
    post(6, 5'd12);
    expect_grant(6, 5'd12);
    @(negedge clk);
    post(6, 5'd20);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    stall = 1'b0;
    idle(5);

    // Reset during the grant of source 0 with source 3 still pending.
    @(negedge clk);
    post(0, 5'd5);
    post(3, 5'd6);
    expect_grant(0, 5'd5);
    @(negedge clk);
    req = '0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_we",    32'(reg_write), 32'd0);
    check("rst_mid_done",  32'(wb_done),   32'd0);
    check("rst_mid_busy",  32'(busy),      32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'h7f);
    @(negedge clk);
    reset = 1'b0;
    idle(6);

    // Randomised single requests on a free port.
    for (int n = 0; n < 20; n++) begin
      int s;
      logic [REG_W-1:0] r;
      s = $urandom_range(0, N_SRC - 1);
      r = REG_W'($urandom_range(0, 31));
      @(negedge clk);
      post(s, r);
      expect_grant(s, r);
      @(negedge clk);
      req = '0;
      idle($urandom_range(1, 3));
    end

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
    check("drain", 32'(exp_q.size()), 32'd0);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
